// File: rtl/hazard_unit_pkg.sv
// Opcode map, decode helpers and scoreboard entry type shared by
// the hazard unit and the ID-stage controller.
package hazard_unit_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000001;
    localparam logic [5:0] OP_SUB   = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b000011;
    localparam logic [5:0] OP_OR    = 6'b000100;
    localparam logic [5:0] OP_XOR   = 6'b000101;
    localparam logic [5:0] OP_NOR   = 6'b000110;
    localparam logic [5:0] OP_SLT   = 6'b000111;
    localparam logic [5:0] OP_SLTU  = 6'b001000;
    localparam logic [5:0] OP_MUL   = 6'b001001;
    localparam logic [5:0] OP_SLL   = 6'b001010;
    localparam logic [5:0] OP_SRA   = 6'b001011;
    localparam logic [5:0] OP_SRL   = 6'b001100;
    localparam logic [5:0] OP_ADDI  = 6'b100000;
    localparam logic [5:0] OP_SUBI  = 6'b100001;
    localparam logic [5:0] OP_LOAD  = 6'b100100;
    localparam logic [5:0] OP_STORE = 6'b100101;
    localparam logic [5:0] OP_BEZ   = 6'b101000;
    localparam logic [5:0] OP_BNE   = 6'b101001;
    localparam logic [5:0] OP_JMP   = 6'b101010;

    // Entries hold register numbers up to this width, zero-extended.
    localparam int SB_DEST_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [SB_DEST_W-1:0] dest;
        logic                 is_load;
    } sb_entry_t;

    function automatic logic is_rtype(input logic [5:0] op);
        return (op >= OP_ADD) && (op <= OP_SRL);
    endfunction

    function automatic logic uses_src1(input logic [5:0] op);
        return is_rtype(op) || op == OP_ADDI || op == OP_SUBI ||
               op == OP_LOAD || op == OP_STORE ||
               op == OP_BEZ || op == OP_BNE;
    endfunction

    function automatic logic uses_src2(input logic [5:0] op);
        return is_rtype(op) || op == OP_STORE || op == OP_BNE;
    endfunction

    function automatic logic writes_reg(input logic [5:0] op);
        return is_rtype(op) || op == OP_ADDI || op == OP_SUBI ||
               op == OP_LOAD;
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return op == OP_LOAD;
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return op == OP_BEZ || op == OP_BNE || op == OP_JMP;
    endfunction

    function automatic logic is_cond_branch(input logic [5:0] op);
        return op == OP_BEZ || op == OP_BNE;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter with synchronous active-low clear.
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en && count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall / flush generation from a shadow scoreboard of the
// instructions currently in EX and MEM.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int FORWARDING = 1,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  branch_taken,
    output logic                  hazard,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  ifid_flush,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    sb_entry_t ex_q;
    sb_entry_t mem_q;

    logic ex_hit;
    logic mem_hit;

    function automatic logic sb_match(
        input sb_entry_t             e,
        input logic [REG_ADDR_W-1:0] r
    );
        return e.valid && (e.dest != '0) &&
               (e.dest == SB_DEST_W'(r));
    endfunction

    always_comb begin
        ex_hit  = (uses_src1(opcode) && sb_match(ex_q, src1)) ||
                  (uses_src2(opcode) && sb_match(ex_q, src2));
        mem_hit = (uses_src1(opcode) && sb_match(mem_q, src1)) ||
                  (uses_src2(opcode) && sb_match(mem_q, src2));
        hazard  = 1'b0;
        if (FORWARDING != 0) begin
            // Branches compare in ID, ahead of the forwarding muxes.
            if (is_cond_branch(opcode)) begin
                hazard = ex_hit || (mem_hit && mem_q.is_load);
            end else begin
                hazard = ex_hit && ex_q.is_load;
            end
        end else begin
            hazard = ex_hit || mem_hit;
        end
    end

    assign pc_write_en   = ~hazard;
    assign ifid_write_en = ~hazard;
    assign ifid_flush    = branch_taken && is_branch(opcode) && !hazard;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q <= ex_q;
            if (hazard) begin
                ex_q <= '0;
            end else begin
                ex_q.valid   <= writes_reg(opcode);
                ex_q.dest    <= SB_DEST_W'(dest);
                ex_q.is_load <= is_load(opcode);
            end
        end
    end

    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst),
        .en    (hazard),
        .count (stall_count)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (rst),
        .en    (ifid_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: forwarding, non-forwarding and
// narrow-counter instances share one stimulus bus.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [4:0] src1;
    logic [4:0] src2;
    logic [4:0] dest;
    logic       branch_taken;

    logic [2:0]  hz;
    logic [2:0]  pcw;
    logic [2:0]  ifw;
    logic [2:0]  fl;
    logic [15:0] sc1, fc1, sc0, fc0;
    logic [3:0]  sc2, fc2;

    typedef struct {
        int   sel;
        logic hz;
        logic fl;
        int   sc;
        int   fc;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    hazard_unit #(.FORWARDING(1)) dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .src1(src1),
        .src2(src2), .dest(dest), .branch_taken(branch_taken),
        .hazard(hz[1]), .pc_write_en(pcw[1]),
        .ifid_write_en(ifw[1]), .ifid_flush(fl[1]),
        .stall_count(sc1), .flush_count(fc1)
    );

    hazard_unit #(.FORWARDING(0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .src1(src1),
        .src2(src2), .dest(dest), .branch_taken(branch_taken),
        .hazard(hz[0]), .pc_write_en(pcw[0]),
        .ifid_write_en(ifw[0]), .ifid_flush(fl[0]),
        .stall_count(sc0), .flush_count(fc0)
    );

    hazard_unit #(.FORWARDING(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .src1(src1),
        .src2(src2), .dest(dest), .branch_taken(branch_taken),
        .hazard(hz[2]), .pc_write_en(pcw[2]),
        .ifid_write_en(ifw[2]), .ifid_flush(fl[2]),
        .stall_count(sc2), .flush_count(fc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input string f,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, exp);
        end
    endtask

    task automatic vec(input string nm, input logic r,
                       input logic [5:0] op, input int s1, input int s2,
                       input int d, input logic bt, input int sel,
                       input logic ehz, input logic efl,
                       input int esc, input int efc);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        opcode       = op;
        src1         = 5'(s1);
        src2         = 5'(s2);
        dest         = 5'(d);
        branch_taken = bt;
        e.sel = sel; e.hz = ehz; e.fl = efl; e.sc = esc; e.fc = efc;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    // Monitor: combinational outputs settle mid-cycle.
    initial begin
        exp_t  e;
        string nm;
        logic [31:0] a_sc, a_fc;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e  = q.pop_front();
                nm = nq.pop_front();
                case (e.sel)
                    0:       begin a_sc = 32'(sc0); a_fc = 32'(fc0); end
                    1:       begin a_sc = 32'(sc1); a_fc = 32'(fc1); end
                    default: begin a_sc = 32'(sc2); a_fc = 32'(fc2); end
                endcase
                chk(nm, "hazard", 32'(hz[e.sel]), 32'(e.hz));
                chk(nm, "pc_we", 32'(pcw[e.sel]), 32'(!e.hz));
                chk(nm, "ifid_we", 32'(ifw[e.sel]), 32'(!e.hz));
                chk(nm, "flush", 32'(fl[e.sel]), 32'(e.fl));
                chk(nm, "stall_cnt", a_sc, 32'(e.sc));
                chk(nm, "flush_cnt", a_fc, 32'(e.fc));
            end
        end
    end

    initial begin
        int run;
        logic ehz;
        rst = 1'b0; opcode = '0; src1 = '0; src2 = '0;
        dest = '0; branch_taken = 1'b0;

        // Forwarding instance
        vec("rst_load",  0, OP_LOAD, 1, 0, 5, 0, 1, 0, 0, 0, 0);
        vec("rst_add",   0, OP_ADD,  5, 1, 6, 0, 1, 0, 0, 0, 0);
        vec("load_r5",   1, OP_LOAD, 1, 0, 5, 0, 1, 0, 0, 0, 0);
        vec("lu_stall",  1, OP_ADD,  5, 1, 6, 0, 1, 1, 0, 0, 0);
        vec("lu_issue",  1, OP_ADD,  5, 1, 6, 0, 1, 0, 0, 1, 0);
        vec("addi_r0",   1, OP_ADDI, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        vec("bez_r0",    1, OP_BEZ,  0, 0, 0, 0, 1, 0, 0, 1, 0);
        vec("add_r3",    1, OP_ADD,  1, 2, 3, 0, 1, 0, 0, 1, 0);
        vec("br_stall",  1, OP_BEZ,  3, 0, 0, 1, 1, 1, 0, 1, 0);
        vec("br_flush",  1, OP_BEZ,  3, 0, 0, 1, 1, 0, 1, 2, 0);
        vec("jmp",       1, OP_JMP,  0, 0, 0, 1, 1, 0, 1, 2, 1);
        vec("nop_bt",    1, 6'd0,    0, 0, 0, 1, 1, 0, 0, 2, 2);
        vec("load_r9",   1, OP_LOAD, 1, 0, 9, 0, 1, 0, 0, 2, 2);
        vec("nop",       1, 6'd0,    0, 0, 0, 0, 1, 0, 0, 2, 2);
        vec("bne_ldmem", 1, OP_BNE,  2, 9, 0, 0, 1, 1, 0, 2, 2);
        vec("bne_go",    1, OP_BNE,  2, 9, 0, 0, 1, 0, 0, 3, 2);
        vec("load_r5b",  1, OP_LOAD, 1, 0, 5, 0, 1, 0, 0, 3, 2);
        vec("rst_stall", 0, OP_ADD,  5, 1, 6, 0, 1, 1, 0, 3, 2);
        vec("post_rst",  1, OP_ADD,  5, 1, 6, 0, 1, 0, 0, 0, 0);

        // Non-forwarding instance
        vec("nf_rst",    0, 6'd0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("nf_sub",    1, OP_SUB,  1, 2, 4, 0, 0, 0, 0, 0, 0);
        vec("nf_raw_ex", 1, OP_OR,   4, 2, 8, 0, 0, 1, 0, 0, 0);
        vec("nf_raw_mem",1, OP_OR,   4, 2, 8, 0, 0, 1, 0, 1, 0);
        vec("nf_issue",  1, OP_OR,   4, 2, 8, 0, 0, 0, 0, 2, 0);
        vec("nf_jmp",    1, OP_JMP,  0, 0, 0, 1, 0, 0, 1, 2, 0);
        vec("nf_nop",    1, 6'd0,    0, 0, 0, 0, 0, 0, 0, 2, 1);

        // Narrow-counter instance, saturation
        vec("sat_rst",   0, 6'd0,    0, 0, 0, 0, 2, 0, 0, 2, 1);
        vec("sat_sub",   1, OP_SUB,  1, 2, 4, 0, 2, 0, 0, 0, 0);
        run = 0;
        for (int i = 0; i < 27; i++) begin
            ehz = (i % 3) != 2;
            vec("sat_loop", 1, OP_OR, 4, 4, 4, 0, 2, ehz, 0,
                (run > 15) ? 15 : run, 0);
            if (ehz) run++;
        end
        vec("sat_hold",  1, 6'd0,    0, 0, 0, 0, 2, 0, 0, 15, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d pending, expected 0", q.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
